// File: rtl/jtag_master_if.sv
// rtl/jtag_master_if.sv - command/response channel of the JTAG initiator
interface jtag_master_if #(parameter int MAX_LEN = 64);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [6:0]         cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/jtag_master.sv
// rtl/jtag_master.sv - command-driven IEEE 1149.1 TAP initiator
// Each TCK period is one step; pins load at the falling edge, TDO samples on the rising edge.
module jtag_master #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 64
) (
  input  logic         clk,
  input  logic         rstn,
  jtag_master_if.slave bus,
  output logic         jtag_tck,
  output logic         jtag_tms,
  output logic         jtag_tdi,
  input  logic         jtag_tdo,
  output logic         jtag_trstn
);
  localparam int         IW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [6:0] LEN_MAX  = 7'(MAX_LEN);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_RST, S_DR_PRE, S_IR_PRE, S_SHIFT, S_POST, S_RUN, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [6:0]         cnt_q, cnt_d, len_q, len_d, scan_len;
  logic [7:0]         div_q, div_d;
  logic [1:0]         op_q, op_d;
  logic [MAX_LEN-1:0] data_q, data_d, rsp_data_q, rsp_data_d;
  logic               tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic               trstn_q, trstn_d, tap_known_q, tap_known_d, load_pins;

  function automatic logic step_tms(state_t st, logic [6:0] c, logic [6:0] n);
    case (st)
      S_RST:    return c < 7'd5;
      S_DR_PRE: return c == 7'd0;
      S_IR_PRE: return c < 7'd2;
      S_SHIFT:  return c == n - 7'd1;
      S_POST:   return c == 7'd0;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [6:0] step_last(state_t st, logic [6:0] n);
    case (st)
      S_RST:    return 7'd5;
      S_DR_PRE: return 7'd2;
      S_IR_PRE: return 7'd3;
      S_POST:   return 7'd1;
      S_SHIFT,
      S_RUN:    return n - 7'd1;
      default:  return 7'd0;
    endcase
  endfunction

  // First state of an op once the TAP sits in Run-Test/Idle.
  function automatic state_t op_entry(logic [1:0] op, logic [6:0] n);
    case (op)
      2'd1:    return S_IR_PRE;
      2'd2:    return S_DR_PRE;
      2'd3:    return (n == 7'd0) ? S_DONE : S_RUN;
      default: return S_DONE;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    div_d       = div_q;
    op_d        = op_q;
    data_d      = data_q;
    rsp_data_d  = rsp_data_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    trstn_d     = trstn_q;
    tap_known_d = tap_known_q;
    load_pins   = 1'b0;
    scan_len    = bus.cmd_len;
    if (bus.cmd_len == 7'd0)         scan_len = 7'd1;
    else if (bus.cmd_len > LEN_MAX)  scan_len = LEN_MAX;

    case (state_q)
      S_INIT: begin
        state_d = S_IDLE;
        trstn_d = 1'b1;
      end
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d       = bus.cmd_op;
          len_d      = (bus.cmd_op == 2'd1 || bus.cmd_op == 2'd2) ? scan_len : bus.cmd_len;
          data_d     = bus.cmd_data;
          rsp_data_d = '0;
          cnt_d      = 7'd0;
          state_d    = (bus.cmd_op == 2'd0 || !tap_known_q) ? S_RST
                                                            : op_entry(bus.cmd_op, bus.cmd_len);
          load_pins  = 1'b1;
        end
      end
      S_DONE: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: begin
        if (div_q == DIV_LAST) begin
          div_d = 8'd0;
          tck_d = ~tck_q;
          if (!tck_q) begin
            if (state_q == S_SHIFT) rsp_data_d[cnt_q[IW-1:0]] = jtag_tdo;
          end else begin
            load_pins = 1'b1;
            if (cnt_q == step_last(state_q, len_q)) begin
              cnt_d = 7'd0;
              case (state_q)
                S_RST: begin
                  tap_known_d = 1'b1;
                  state_d     = op_entry(op_q, len_q);
                end
                S_DR_PRE, S_IR_PRE: state_d = S_SHIFT;
                S_SHIFT:            state_d = S_POST;
                default:            state_d = S_DONE;
              endcase
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
    endcase

    if (load_pins) begin
      tms_d   = step_tms(state_d, cnt_d, len_d);
      tdi_d   = (state_d == S_SHIFT) && data_d[cnt_d[IW-1:0]];
      trstn_d = !(state_d == S_RST && cnt_d == 7'd0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      len_q       <= '0;
      div_q       <= '0;
      op_q        <= '0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      trstn_q     <= 1'b0;
      tap_known_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      div_q       <= div_d;
      op_q        <= op_d;
      data_q      <= data_d;
      rsp_data_q  <= rsp_data_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      trstn_q     <= trstn_d;
      tap_known_q <= tap_known_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_DONE);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = !(state_q == S_INIT || state_q == S_IDLE || state_q == S_DONE);
  assign jtag_tck      = tck_q;
  assign jtag_tms      = tms_q;
  assign jtag_tdi      = tdi_q;
  assign jtag_trstn    = trstn_q;
endmodule
